step_sequencer: RTL and testbench

Control-step sequencer for the simple processor. It sits directly upstream of the one-hot step decoder and drives that decoder's 4-bit `current_state` input. On `run` it latches an instruction and steps `current_state` through time-steps T0..Tn, where n depends on the opcode. It signals `done` on the final step, then returns to T0 for the next fetch.

---
 rtl/proc_pkg.sv | 43 ++++
 rtl/step_sequencer_if.sv | 26 ++
 rtl/step_counter.sv | 29 ++
 rtl/step_sequencer.sv | 70 +++++++
 tb/tb_step_sequencer.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/proc_pkg.sv
// Shared processor control definitions: opcodes, control-step constants and
// the per-opcode final step used by the step sequencer and datapath control.
package proc_pkg;

    localparam int unsigned STEP_W = 4;
    localparam int unsigned OPC_W  = 3;

    typedef logic [STEP_W-1:0] step_t;

    localparam step_t T0 = 4'd0;
    localparam step_t T1 = 4'd1;
    localparam step_t T2 = 4'd2;
    localparam step_t T3 = 4'd3;
    localparam step_t T4 = 4'd4;
    localparam step_t T5 = 4'd5;
    localparam step_t T6 = 4'd6;
    localparam step_t T7 = 4'd7;
    localparam step_t T8 = 4'd8;

    typedef enum logic [OPC_W-1:0] {
        OP_MV   = 3'b000,
        OP_MVI  = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_LD   = 3'b100,
        OP_ST   = 3'b101,
        OP_MVNZ = 3'b110,
        OP_RSV  = 3'b111
    } opcode_e;

    // Last control step of each instruction; reserved opcodes end in T1.
    function automatic step_t final_step(input opcode_e opcode);
        step_t fs;
        fs = T1;
        case (opcode)
            OP_ADD, OP_SUB: fs = T3;
            OP_LD,  OP_ST:  fs = T4;
            default:        fs = T1;
        endcase
        return fs;
    endfunction

endpackage

// File: rtl/step_sequencer_if.sv
// Handshake between the instruction source and the step sequencer.
interface step_sequencer_if #(
    parameter int unsigned INSTR_W = 9
);

    logic                          run;
    logic                          stall;
    logic [INSTR_W-1:0]            instr;
    logic [proc_pkg::STEP_W-1:0]   current_state;
    logic [INSTR_W-1:0]            ir;
    logic                          ir_load;
    logic                          busy;
    logic                          done;
    logic                          illegal;

    modport master (
        output run, stall, instr,
        input  current_state, ir, ir_load, busy, done, illegal
    );

    modport slave (
        input  run, stall, instr,
        output current_state, ir, ir_load, busy, done, illegal
    );

endinterface

// File: rtl/step_counter.sv
// Control-step register with clear / hold / increment, clear having priority.
module step_counter
    import proc_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  clear_i,
    input  logic  hold_i,
    input  logic  inc_i,
    output step_t count_o
);

    step_t count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= T0;
        end else if (clear_i) begin
            count_q <= T0;
        end else if (hold_i) begin
            count_q <= count_q;
        end else if (inc_i) begin
            count_q <= count_q + STEP_W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/step_sequencer.sv
// Control-step sequencer: latches an instruction on run and walks T0..Tn,
// where n is the final step of the latched opcode, feeding the step decoder.
module step_sequencer
    import proc_pkg::*;
#(
    parameter int unsigned INSTR_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    step_sequencer_if.slave  bus
);

    step_t              state_q;
    logic [INSTR_W-1:0] ir_q;
    opcode_e            opc;
    step_t              fin;
    logic               start_c;
    logic               in_range_c;
    logic               clear_c;
    logic               hold_c;
    logic               inc_c;

    // Next-step control; out-of-range values fall back to T0 regardless of stall.
    always_comb begin
        opc        = opcode_e'(ir_q[INSTR_W-1 -: OPC_W]);
        fin        = final_step(opc);
        start_c    = (state_q == T0) && bus.run && !bus.stall;
        in_range_c = (state_q <= T8);
        clear_c    = 1'b0;
        hold_c     = 1'b0;
        inc_c      = 1'b0;
        if (state_q == T0) begin
            inc_c = start_c;
        end else if (!in_range_c) begin
            clear_c = 1'b1;
        end else if (bus.stall) begin
            hold_c = 1'b1;
        end else if ((state_q == fin) || (state_q == T8)) begin
            clear_c = 1'b1;
        end else begin
            inc_c = 1'b1;
        end
    end

    step_counter u_step_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (clear_c),
        .hold_i  (hold_c),
        .inc_i   (inc_c),
        .count_o (state_q)
    );

    // Instruction register only loads in the start cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q <= '0;
        end else if (start_c) begin
            ir_q <= bus.instr;
        end
    end

    assign bus.current_state = state_q;
    assign bus.ir            = ir_q;
    assign bus.ir_load       = start_c;
    assign bus.busy          = (state_q != T0);
    assign bus.done          = in_range_c && (state_q != T0) && (state_q == fin) && !bus.stall;
    assign bus.illegal       = (state_q == T1) && (opc == OP_RSV);

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: directed scenarios plus random traffic against a
// cycle-level behavioural model of the instruction timing rules.
module tb_step_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    step_sequencer_if #(.INSTR_W(9)) bus ();

    step_sequencer #(.INSTR_W(9)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: current step and latched instruction
    int         m_st = 0;
    logic [8:0] m_ir = '0;
    int         fin_tab [8] = '{1, 1, 3, 3, 4, 4, 1, 1};

    function automatic logic [16:0] exp_vec();
        int   fin;
        logic ld, bz, dn, il;
        fin = fin_tab[m_ir[8:6]];
        ld  = (m_st == 0) && bus.run && !bus.stall;
        bz  = (m_st != 0);
        dn  = (m_st != 0) && (m_st == fin) && !bus.stall;
        il  = (m_st == 1) && (m_ir[8:6] == 3'b111);
        return {4'(m_st), m_ir, ld, bz, dn, il};
    endfunction

    function automatic logic [16:0] act_vec();
        return {bus.current_state, bus.ir, bus.ir_load, bus.busy, bus.done, bus.illegal};
    endfunction

    function automatic void model_step();
        if (m_st == 0) begin
            if (bus.run && !bus.stall) begin
                m_ir = bus.instr;
                m_st = 1;
            end
        end else if (!bus.stall) begin
            m_st = (m_st == fin_tab[m_ir[8:6]]) ? 0 : m_st + 1;
        end
    endfunction

    task automatic set_in(input logic r, input logic s, input logic [8:0] i);
        bus.run   = r;
        bus.stall = s;
        bus.instr = i;
    endtask

    task automatic clk_edge();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        logic [16:0] v;
        set_in(1'b0, 1'b0, 9'd0);
        #1 rst_n = 1'b0;
        @(negedge clk);
        v = act_vec();
        n_checks++;
        if (v !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_init act=%h exp=%h", v, 17'd0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        m_st = 0;
        m_ir = '0;
        // advance an add to T3, then reset asynchronously mid-instruction
        set_in(1'b1, 1'b0, 9'b010_001_010);
        clk_edge();
        set_in(1'b0, 1'b0, 9'b010_001_010);
        clk_edge();
        clk_edge();
        n_checks++;
        if (bus.current_state !== 4'd3) begin
            n_fail++;
            $display("FAIL reset_pre_state act=%0d exp=3", bus.current_state);
        end
        #2 rst_n = 1'b0;
        #1;
        v = act_vec();
        n_checks++;
        if (v !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_async act=%h exp=%h", v, 17'd0);
        end
        m_st = 0;
        m_ir = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            v = act_vec();
            n_checks++;
            if (v !== exp_vec() || bus.current_state !== 4'd0) begin
                n_fail++;
                $display("FAIL reset_idle cyc=%0d act=%h exp=%h", k, v, exp_vec());
            end
            clk_edge();
        end
    endtask

    task automatic test_add();
        int   exp_st [5] = '{0, 1, 2, 3, 0};
        logic [16:0] v;
        for (int k = 0; k < 5; k++) begin
            set_in(k == 0, 1'b0, 9'b010_001_010);
            @(negedge clk);
            v = act_vec();
            n_checks++;
            if (v !== exp_vec()) begin
                n_fail++;
                $display("FAIL add_model cyc=%0d act=%h exp=%h", k, v, exp_vec());
            end
            n_checks++;
            if (bus.current_state !== 4'(exp_st[k]) || bus.done !== (k == 3) || bus.ir_load !== (k == 0)) begin
                n_fail++;
                $display("FAIL add_seq cyc=%0d act=%0d/%b/%b exp=%0d/%b/%b", k,
                         bus.current_state, bus.done, bus.ir_load, exp_st[k], k == 3, k == 0);
            end
            if (k == 1) begin
                n_checks++;
                if (bus.ir !== 9'b010001010) begin
                    n_fail++;
                    $display("FAIL add_ir act=%b exp=%b", bus.ir, 9'b010001010);
                end
            end
            clk_edge();
        end
    endtask

    task automatic test_back_to_back();
        int   exp_st [8] = '{0, 1, 0, 1, 2, 3, 4, 0};
        logic [16:0] v;
        for (int k = 0; k < 8; k++) begin
            set_in(k < 7, 1'b0, (k == 0) ? 9'b000_011_101 : 9'b100_010_001);
            @(negedge clk);
            v = act_vec();
            n_checks++;
            if (v !== exp_vec() || bus.current_state !== 4'(exp_st[k]) ||
                bus.done !== (k == 1 || k == 6)) begin
                n_fail++;
                $display("FAIL b2b cyc=%0d act=%h exp=%h state_exp=%0d", k, v, exp_vec(), exp_st[k]);
            end
            clk_edge();
        end
    endtask

    task automatic test_stall();
        int   exp_st [9] = '{0, 1, 2, 2, 2, 3, 4, 4, 0};
        logic [16:0] v;
        for (int k = 0; k < 9; k++) begin
            set_in(k == 0, (k == 2 || k == 3 || k == 6), 9'b100_111_000);
            @(negedge clk);
            v = act_vec();
            n_checks++;
            if (v !== exp_vec() || bus.current_state !== 4'(exp_st[k]) || bus.done !== (k == 7)) begin
                n_fail++;
                $display("FAIL stall cyc=%0d act=%h exp=%h state_exp=%0d", k, v, exp_vec(), exp_st[k]);
            end
            clk_edge();
        end
    endtask

    task automatic test_reserved();
        logic [16:0] v;
        for (int k = 0; k < 3; k++) begin
            set_in(k == 0, 1'b0, 9'b111_101_011);
            @(negedge clk);
            v = act_vec();
            n_checks++;
            if (v !== exp_vec() || bus.current_state !== 4'((k == 1) ? 1 : 0) ||
                bus.illegal !== (k == 1) || bus.done !== (k == 1)) begin
                n_fail++;
                $display("FAIL reserved cyc=%0d act=%h exp=%h", k, v, exp_vec());
            end
            clk_edge();
        end
    endtask

    task automatic test_ignored_inputs();
        int   exp_st [5] = '{0, 1, 2, 3, 0};
        logic [16:0] v;
        for (int k = 0; k < 5; k++) begin
            if (k == 0) set_in(1'b1, 1'b0, 9'b011_100_110);
            else        set_in((k % 2) == 1 && k < 4, 1'b0, 9'($urandom));
            @(negedge clk);
            v = act_vec();
            n_checks++;
            if (v !== exp_vec() || bus.current_state !== 4'(exp_st[k]) ||
                (k > 0 && bus.ir !== 9'b011_100_110)) begin
                n_fail++;
                $display("FAIL ignored cyc=%0d act=%h exp=%h", k, v, exp_vec());
            end
            clk_edge();
        end
    endtask

    task automatic test_random();
        logic [16:0] v;
        int          bad = 0;
        for (int k = 0; k < 400; k++) begin
            set_in(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 9'($urandom));
            @(negedge clk);
            v = act_vec();
            n_checks++;
            if (v !== exp_vec()) begin
                n_fail++;
                bad++;
                if (bad < 10) $display("FAIL random cyc=%0d act=%h exp=%h", k, v, exp_vec());
            end
            clk_edge();
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_stall();
        test_reserved();
        test_ignored_inputs();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
